// File: rtl/ssqa_pkg.sv
// Shared types and helpers for the SSQA sequencer: FSM state encoding,
// default iteration width and the saturating schedule-step function.
package ssqa_pkg;

  localparam int unsigned ITER_WIDTH_DEF = 16;
  localparam int unsigned SAT_W          = 32;

  typedef enum logic [2:0] {
    IDLE,
    CLR,
    ACC,
    DRAIN,
    UPD,
    NEXT,
    FIN
  } ctrl_state_t;

  // x <= min(x+step, max_v); holds when step<=0 or x already at/over the ceiling.
  // The sum is one bit wider than the operands so it can never wrap.
  function automatic logic signed [SAT_W-1:0] sat_add_step(
    input logic signed [SAT_W-1:0] x,
    input logic signed [SAT_W-1:0] step,
    input logic signed [SAT_W-1:0] max_v
  );
    logic signed [SAT_W:0] sum;
    sum = $signed({x[SAT_W-1], x}) + $signed({step[SAT_W-1], step});
    if (step <= 0 || x >= max_v) return x;
    if (sum > $signed({max_v[SAT_W-1], max_v})) return max_v;
    return sum[SAT_W-1:0];
  endfunction

endpackage

// File: rtl/ssqa_sched.sv
// One annealing schedule register (I0 or Q): loads its minimum on job start,
// then steps towards its ceiling with saturation when the controller asks.
module ssqa_sched
  import ssqa_pkg::*;
#(
  parameter int unsigned W = 8
) (
  input  logic                clk,
  input  logic                i_rst,
  input  logic                i_load,
  input  logic                i_step,
  input  logic signed [W-1:0] i_min,
  input  logic signed [W-1:0] i_max,
  input  logic signed [W-1:0] i_incr,
  output logic signed [W-1:0] o_val
);

  logic signed [W-1:0] r_val;
  logic signed [W-1:0] r_max;
  logic signed [W-1:0] r_incr;

  always_ff @(posedge clk) begin
    if (i_rst) begin
      r_val  <= '0;
      r_max  <= '0;
      r_incr <= '0;
    end else if (i_load) begin
      r_val  <= i_min;
      r_max  <= i_max;
      r_incr <= i_incr;
    end else if (i_step) begin
      r_val <= W'(sat_add_step(SAT_W'(r_val), SAT_W'(r_incr), SAT_W'(r_max)));
    end
  end

  assign o_val = r_val;

endmodule

// File: rtl/ssqa_ctrl.sv
// Upstream sequencer for the SSQA replica array: runs num_iter sweeps over all
// spins/couplings, driving array strobes, counters and the I0/Q schedule.
module ssqa_ctrl
  import ssqa_pkg::*;
#(
  parameter int unsigned N          = 800,
  parameter int unsigned NN         = 800,
  parameter int unsigned TEM_WIDTH  = 8,
  parameter int unsigned ITER_WIDTH = ITER_WIDTH_DEF
) (
  input  logic                        clk,
  input  logic                        rst_ini,
  input  logic                        start,
  input  logic [ITER_WIDTH-1:0]       num_iter,
  input  logic [7:0]                  tau,
  input  logic signed [TEM_WIDTH-1:0] i0_min,
  input  logic signed [TEM_WIDTH-1:0] i0_max,
  input  logic signed [TEM_WIDTH-1:0] i0_step,
  input  logic signed [TEM_WIDTH-1:0] q_min,
  input  logic signed [TEM_WIDTH-1:0] q_max,
  input  logic signed [TEM_WIDTH-1:0] q_step,
  output logic                        en_read,
  output logic                        en_mult,
  output logic                        en_upd,
  output logic                        rst_iter,
  output logic [$clog2(NN)-1:0]       count_spin,
  output logic [$clog2(NN)-1:0]       count_bit,
  output logic [ITER_WIDTH-1:0]       count_iter,
  output logic signed [TEM_WIDTH-1:0] I0,
  output logic signed [TEM_WIDTH-1:0] Q,
  output logic                        busy,
  output logic                        done
);

  localparam int unsigned CW = $clog2(NN);
  localparam logic [CW-1:0] LAST_BIT  = CW'(NN - 1);
  localparam logic [CW-1:0] LAST_SPIN = CW'(N - 1);

  ctrl_state_t             r_state;
  ctrl_state_t             w_next;
  logic [CW-1:0]           r_count_spin;
  logic [CW-1:0]           r_count_bit;
  logic [ITER_WIDTH-1:0]   r_count_iter;
  logic [ITER_WIDTH-1:0]   r_num_iter;
  logic [ITER_WIDTH-1:0]   w_iter_inc;
  logic [7:0]              r_tau;
  logic [7:0]              r_tau_cnt;
  logic                    r_busy;
  logic                    r_en_mult;
  logic                    w_tau_hit;
  logic                    w_load;
  logic                    w_step;

  assign w_iter_inc = r_count_iter + ITER_WIDTH'(1);
  // A sweep counter modulo tau replaces (count_iter+1)%tau==0 without a divider.
  assign w_tau_hit  = (r_tau != '0) && (r_tau_cnt == r_tau - 8'd1);

  always_ff @(posedge clk) begin
    if (rst_ini) r_state <= IDLE;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    if (start) w_next = (num_iter == '0) ? FIN : CLR;
      CLR:     w_next = ACC;
      ACC:     if (r_count_bit == LAST_BIT) w_next = DRAIN;
      DRAIN:   w_next = UPD;
      UPD:     w_next = (r_count_spin == LAST_SPIN) ? NEXT : CLR;
      NEXT:    w_next = (w_iter_inc == r_num_iter) ? FIN : CLR;
      FIN:     w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    rst_iter = 1'b0;
    en_read  = 1'b0;
    en_upd   = 1'b0;
    done     = 1'b0;
    w_load   = 1'b0;
    w_step   = 1'b0;
    case (r_state)
      IDLE:    w_load   = start;
      CLR:     rst_iter = 1'b1;
      ACC:     en_read  = 1'b1;
      UPD:     en_upd   = 1'b1;
      NEXT:    w_step   = w_tau_hit;
      FIN:     done     = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst_ini) begin
      r_count_spin <= '0;
      r_count_bit  <= '0;
      r_count_iter <= '0;
      r_num_iter   <= '0;
      r_tau        <= '0;
      r_tau_cnt    <= '0;
      r_busy       <= 1'b0;
      r_en_mult    <= 1'b0;
    end else begin
      r_en_mult <= en_read;
      case (r_state)
        IDLE: if (start) begin
          r_num_iter   <= num_iter;
          r_tau        <= tau;
          r_tau_cnt    <= '0;
          r_count_spin <= '0;
          r_count_bit  <= '0;
          r_count_iter <= '0;
          r_busy       <= 1'b1;
        end
        CLR:  r_count_bit <= '0;
        ACC:  if (r_count_bit != LAST_BIT) r_count_bit <= r_count_bit + CW'(1);
        UPD:  if (r_count_spin != LAST_SPIN) r_count_spin <= r_count_spin + CW'(1);
        NEXT: begin
          r_count_spin <= '0;
          r_count_iter <= w_iter_inc;
          if (r_tau != '0) r_tau_cnt <= w_tau_hit ? '0 : r_tau_cnt + 8'd1;
        end
        FIN:  r_busy <= 1'b0;
        default: ;
      endcase
    end
  end

  ssqa_sched #(.W(TEM_WIDTH)) u_sched_i0 (
    .clk    (clk),
    .i_rst  (rst_ini),
    .i_load (w_load),
    .i_step (w_step),
    .i_min  (i0_min),
    .i_max  (i0_max),
    .i_incr (i0_step),
    .o_val  (I0)
  );

  ssqa_sched #(.W(TEM_WIDTH)) u_sched_q (
    .clk    (clk),
    .i_rst  (rst_ini),
    .i_load (w_load),
    .i_step (w_step),
    .i_min  (q_min),
    .i_max  (q_max),
    .i_incr (q_step),
    .o_val  (Q)
  );

  assign en_mult    = r_en_mult;
  assign count_spin = r_count_spin;
  assign count_bit  = r_count_bit;
  assign count_iter = r_count_iter;
  assign busy       = r_busy;

endmodule

// File: tb/tb_ssqa_ctrl.sv
// Directed bench for ssqa_ctrl (N=4, NN=4): each job's expected strobe counts,
// latency and I0/Q trajectory are queued at launch and checked at done.
module tb_ssqa_ctrl;

  localparam int N  = 4;
  localparam int NN = 4;

  logic              clk;
  logic              rst_ini;
  logic              start;
  logic [15:0]       num_iter;
  logic [7:0]        tau;
  logic signed [7:0] i0_min, i0_max, i0_step, q_min, q_max, q_step;
  logic              en_read, en_mult, en_upd, rst_iter;
  logic [1:0]        count_spin, count_bit;
  logic [15:0]       count_iter;
  logic signed [7:0] I0, Q;
  logic              busy, done;

  ssqa_ctrl #(.N(N), .NN(NN), .TEM_WIDTH(8), .ITER_WIDTH(16)) dut (
    .clk        (clk),
    .rst_ini    (rst_ini),
    .start      (start),
    .num_iter   (num_iter),
    .tau        (tau),
    .i0_min     (i0_min),
    .i0_max     (i0_max),
    .i0_step    (i0_step),
    .q_min      (q_min),
    .q_max      (q_max),
    .q_step     (q_step),
    .en_read    (en_read),
    .en_mult    (en_mult),
    .en_upd     (en_upd),
    .rst_iter   (rst_iter),
    .count_spin (count_spin),
    .count_bit  (count_bit),
    .count_iter (count_iter),
    .I0         (I0),
    .Q          (Q),
    .busy       (busy),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int n_rst;
    int n_read;
    int n_mult;
    int n_upd;
    int lat;
    int iter;
    int ntraj;
    int i0_tr[8];
    int q_tr[8];
  } res_t;

  res_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, $signed(obs), $signed(expv));
    end
  endtask

  function automatic int step_model(input int x, input int st, input int mx);
    if (st <= 0 || x >= mx) return x;
    return (x + st > mx) ? mx : x + st;
  endfunction

  task automatic check_all_zero(input string tag);
    chk({tag, "_busy"},   32'(busy), 0);
    chk({tag, "_done"},   32'(done), 0);
    chk({tag, "_strobe"}, 32'({en_read, en_mult, en_upd, rst_iter}), 0);
    chk({tag, "_cspin"},  32'(count_spin), 0);
    chk({tag, "_cbit"},   32'(count_bit), 0);
    chk({tag, "_citer"},  32'(count_iter), 0);
    chk({tag, "_I0"},     32'(I0), 0);
    chk({tag, "_Q"},      32'(Q), 0);
  endtask

  // Called at a negedge: drives a start pulse and queues the expected result.
  task automatic launch(input int ni, input int t, input int i0mn, input int i0mx,
                        input int i0st, input int qmn, input int qmx, input int qst);
    res_t e;
    int x, y;
    num_iter = 16'(ni);
    tau      = 8'(t);
    i0_min   = 8'(i0mn);  i0_max = 8'(i0mx);  i0_step = 8'(i0st);
    q_min    = 8'(qmn);   q_max  = 8'(qmx);   q_step  = 8'(qst);
    start    = 1'b1;
    e.n_rst  = ni * N;
    e.n_read = ni * N * NN;
    e.n_mult = ni * N * NN;
    e.n_upd  = ni * N;
    e.lat    = ni * (N * (NN + 3) + 1);
    e.iter   = ni;
    e.ntraj  = ni + 1;
    x = i0mn;
    y = qmn;
    e.i0_tr[0] = x;
    e.q_tr[0]  = y;
    for (int s = 1; s <= ni && s < 8; s++) begin
      if (t != 0 && (s % t) == 0) begin
        x = step_model(x, i0st, i0mx);
        y = step_model(y, qst, qmx);
      end
      e.i0_tr[s] = x;
      e.q_tr[s]  = y;
    end
    exp_q.push_back(e);
  endtask

  task automatic wait_done(input string tag, input bit re_pulse, input bit pulse_on_done);
    res_t o, e;
    int   b_idx, busy_n, fin_i0, fin_q;
    logic [15:0] prev_iter;
    bit   seen_b, seen_d;
    for (int cyc = 1; cyc <= 2000 && !seen_d; cyc++) begin
      @(negedge clk);
      if (rst_iter) o.n_rst++;
      if (en_read)  o.n_read++;
      if (en_mult)  o.n_mult++;
      if (en_upd)   o.n_upd++;
      if (busy)     busy_n++;
      if (busy && !seen_b) begin
        seen_b = 1'b1;
        b_idx = cyc;
        prev_iter = count_iter;
        o.i0_tr[0] = I0;
        o.q_tr[0]  = Q;
        o.ntraj = 1;
      end else if (seen_b && count_iter != prev_iter && o.ntraj < 8) begin
        prev_iter = count_iter;
        o.i0_tr[o.ntraj] = I0;
        o.q_tr[o.ntraj]  = Q;
        o.ntraj++;
      end
      if (done) begin
        seen_d = 1'b1;
        o.lat  = cyc - b_idx;
        o.iter = count_iter;
        fin_i0 = I0;
        fin_q  = Q;
      end
      start = (re_pulse && cyc == 5) || (pulse_on_done && done);
      if (cyc == 1) begin
        // job parameters must have been captured at start
        num_iter = 16'd7; tau = 8'd3;
        i0_min = -8'sd5; i0_max = 8'sd1; i0_step = 8'sd1;
        q_min  = -8'sd5; q_max  = 8'sd1; q_step  = 8'sd1;
      end
    end
    chk({tag, "_done_seen"}, 32'(seen_d), 1);
    e = exp_q.pop_front();
    chk({tag, "_n_rst"},  o.n_rst,  e.n_rst);
    chk({tag, "_n_read"}, o.n_read, e.n_read);
    chk({tag, "_n_mult"}, o.n_mult, e.n_mult);
    chk({tag, "_n_upd"},  o.n_upd,  e.n_upd);
    chk({tag, "_lat"},    o.lat,    e.lat);
    chk({tag, "_busy_n"}, busy_n,   e.lat + 1);
    chk({tag, "_iter"},   o.iter,   e.iter);
    chk({tag, "_ntraj"},  o.ntraj,  e.ntraj);
    for (int k = 0; k < e.ntraj && k < 8; k++) begin
      chk($sformatf("%s_i0_tr%0d", tag, k), o.i0_tr[k], e.i0_tr[k]);
      chk($sformatf("%s_q_tr%0d", tag, k),  o.q_tr[k],  e.q_tr[k]);
    end
    chk({tag, "_fin_i0"}, fin_i0, e.i0_tr[e.ntraj-1]);
    chk({tag, "_fin_q"},  fin_q,  e.q_tr[e.ntraj-1]);
    @(negedge clk);
    chk({tag, "_post_busy"}, 32'(busy), 0);
    chk({tag, "_post_done"}, 32'(done), 0);
    start = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit hit;
    rst_ini = 1'b1;
    start = 1'b0;
    num_iter = '0; tau = '0;
    i0_min = '0; i0_max = '0; i0_step = '0;
    q_min  = '0; q_max  = '0; q_step  = '0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst_ini = 1'b0;
    @(negedge clk);
    check_all_zero("post_reset");

    // 1: single sweep, schedule held constant
    launch(1, 0, -20, 100, 10, 5, 100, 10);
    wait_done("t1", 1'b0, 1'b0);

    // 2: I0 saturates at its ceiling; Q has a negative step and holds
    launch(3, 1, 10, 100, 50, 50, 100, -10);
    wait_done("t2", 1'b0, 1'b0);

    // 3: zero-iteration job
    launch(0, 1, 3, 50, 5, 4, 50, 5);
    wait_done("t3", 1'b0, 1'b0);

    // 4: abort during ACC of the second sweep
    launch(3, 1, 10, 100, 50, 0, 100, 20);
    hit = 1'b0;
    for (int c = 0; c < 500 && !hit; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (count_iter == 16'd1 && en_read) hit = 1'b1;
    end
    chk("t4_reach_sweep2", 32'(hit), 1);
    void'(exp_q.pop_back());
    rst_ini = 1'b1;
    @(negedge clk);
    rst_ini = 1'b0;
    check_all_zero("t4_abort");
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk($sformatf("t4_no_done%0d", c), 32'({done, busy}), 0);
    end
    launch(2, 1, 10, 100, 50, -30, 0, 7);
    wait_done("t4_rerun", 1'b0, 1'b0);

    // 5: start while busy and on the done cycle are ignored; one cycle later is taken
    launch(1, 0, 1, 2, 3, 4, 5, 6);
    wait_done("t5a", 1'b1, 1'b1);
    launch(2, 2, -50, 0, 25, 0, 10, 4);
    wait_done("t5b", 1'b0, 1'b0);

    // 6: Q clamps at 127 without wrapping negative
    launch(2, 1, -100, 0, 30, 120, 127, 20);
    wait_done("t6", 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
